// File: rtl/quad_scan_ctrl_pkg.sv
// Shared types and sizing helper for the quadrature scan controller (package quad_pkg).
package quad_pkg;

    typedef enum logic [1:0] {IDLE, CAPT, ACK} rd_state_t;

    typedef enum logic [2:0] {HOLD, INC1, DEC1, INC2, DEC2} step_t;

    // One code beyond the last channel stays representable so out-of-range reads can be issued.
    function automatic int ch_w(input int channels);
        return $clog2(channels + 1);
    endfunction

endpackage

// File: rtl/quad_step.sv
// Combinational quadrature step decode for one channel slot.
module quad_step
    import quad_pkg::*;
(
    input  logic  a,
    input  logic  b,
    input  logic  prev_a,
    input  logic  prev_b,
    input  logic  dir_in,
    output step_t step,
    output logic  dir_out,
    output logic  skip
);

    always_comb begin
        step    = HOLD;
        dir_out = dir_in;
        skip    = 1'b0;
        case ({a ^ prev_a, b ^ prev_b})
            2'b01, 2'b10: begin
                dir_out = b ^ prev_a;
                step    = (b ^ prev_a) ? INC1 : DEC1;
            end
            2'b11: begin
                // Both phases moved: assume the step continued in the last known direction.
                skip = 1'b1;
                step = dir_in ? INC2 : DEC2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/quad_scan_ctrl.sv
// Round-robin quadrature scanner with per-channel counts and a 4-phase host read port.
// Optional index clear: define QUAD_INDEX_CLEAR_EN.
module quad_scan_ctrl
    import quad_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CHANNELS-1:0]        a,
    input  logic [CHANNELS-1:0]        b,
    input  logic [CHANNELS-1:0]        z,
    input  logic                       rd_req,
    input  logic [ch_w(CHANNELS)-1:0]  rd_ch,
    output logic                       rd_ack,
    output logic [CNT_W-1:0]           rd_cnt,
    output logic                       rd_skip
);

    localparam int CW = ch_w(CHANNELS);
    localparam int IW = $clog2(CHANNELS);

    logic [CHANNELS-1:0] a_m, a_s, b_m, b_s;
    logic [CHANNELS-1:0] prev_a, prev_b, dir, skip;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [CW-1:0]       ptr;
    logic [IW-1:0]       idx;
    logic                zclr;

    step_t               step;
    logic                dir_nxt, step_skip;
    logic [CNT_W-1:0]    cnt_cur, cnt_nxt;

    rd_state_t           state, state_nxt;
    logic [CW-1:0]       rd_sel;
    logic [IW-1:0]       rd_idx;
    logic                sel_ok, cap, cap_clr;

    assign idx     = ptr[IW-1:0];
    assign rd_idx  = rd_sel[IW-1:0];
    assign sel_ok  = (rd_sel < CW'(CHANNELS));
    assign cap_clr = cap & sel_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_m <= '0;
            a_s <= '0;
            b_m <= '0;
            b_s <= '0;
        end else begin
            a_m <= a;
            a_s <= a_m;
            b_m <= b;
            b_s <= b_m;
        end
    end

`ifdef QUAD_INDEX_CLEAR_EN
    logic [CHANNELS-1:0] z_m, z_s, prev_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_m    <= '0;
            z_s    <= '0;
            prev_z <= '0;
        end else begin
            z_m         <= z;
            z_s         <= z_m;
            prev_z[idx] <= z_s[idx];
        end
    end

    assign zclr = z_s[idx] & ~prev_z[idx];
`else
    logic unused_z;
    assign unused_z = ^z;
    assign zclr     = 1'b0;
`endif

    quad_step u_step (
        .a       (a_s[idx]),
        .b       (b_s[idx]),
        .prev_a  (prev_a[idx]),
        .prev_b  (prev_b[idx]),
        .dir_in  (dir[idx]),
        .step    (step),
        .dir_out (dir_nxt),
        .skip    (step_skip)
    );

    always_comb begin
        cnt_cur = cnt[idx];
        cnt_nxt = cnt_cur;
        case (step)
            INC1:    cnt_nxt = cnt_cur + CNT_W'(1);
            DEC1:    cnt_nxt = cnt_cur - CNT_W'(1);
            INC2:    cnt_nxt = cnt_cur + CNT_W'(2);
            DEC2:    cnt_nxt = cnt_cur - CNT_W'(2);
            default: cnt_nxt = cnt_cur;
        endcase
        if (zclr) begin
            cnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            prev_a <= '0;
            prev_b <= '0;
            dir    <= '0;
            skip   <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            ptr         <= (ptr == CW'(CHANNELS - 1)) ? '0 : ptr + CW'(1);
            prev_a[idx] <= a_s[idx];
            prev_b[idx] <= b_s[idx];
            dir[idx]    <= dir_nxt;
            cnt[idx]    <= cnt_nxt;
            // Scanner set is ordered after the read clear so a same-cycle skip survives.
            if (cap_clr) begin
                skip[rd_idx] <= 1'b0;
            end
            if (step_skip) begin
                skip[idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_ack    = 1'b0;
        cap       = 1'b0;
        case (state)
            IDLE: if (rd_req) state_nxt = CAPT;
            CAPT: begin
                cap       = 1'b1;
                state_nxt = ACK;
            end
            ACK: begin
                rd_ack = 1'b1;
                if (!rd_req) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel  <= '0;
            rd_cnt  <= '0;
            rd_skip <= 1'b0;
        end else begin
            if (state == IDLE && rd_req) begin
                rd_sel <= rd_ch;
            end
            if (cap) begin
                rd_cnt  <= sel_ok ? cnt[rd_idx] : '0;
                rd_skip <= sel_ok & skip[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_quad_scan_ctrl.sv
// Randomized scoreboard bench for quad_scan_ctrl against a Gray-position reference model.
module tb_quad_scan_ctrl;
    import quad_pkg::*;

    localparam int CH  = 4;
    localparam int TW  = ch_w(CH);
    localparam int GAP = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [CH-1:0]  a = '0, b = '0, z = '0;
    logic           rd_req = 1'b0;
    logic [TW-1:0]  rd_ch = '0;
    logic           rd_ack;
    logic [15:0]    rd_cnt;
    logic           rd_skip;

    quad_scan_ctrl #(.CHANNELS(CH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .z(z),
        .rd_req(rd_req), .rd_ch(rd_ch), .rd_ack(rd_ack),
        .rd_cnt(rd_cnt), .rd_skip(rd_skip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cnt;
        logic        skip;
        int          cyc;
        int          ch;
    } exp_t;

    exp_t        expq[$];
    exp_t        me;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        ack_q = 1'b0;

    logic [15:0] cnt_m [CH];
    bit          dir_m [CH];
    bit          skip_m [CH];
    logic [1:0]  ab_m [CH];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_ack && !ack_q) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ack: got ack expected none (t=%0t)", $time);
            end else begin
                me = expq.pop_front();
                chk($sformatf("rd_cnt ch%0d", me.ch), 32'(rd_cnt), 32'(me.cnt));
                chk($sformatf("rd_skip ch%0d", me.ch), 32'(rd_skip), 32'(me.skip));
                chk("ack_latency", 32'(cyc - me.cyc), 32'd2);
            end
        end
        ack_q = rd_ack;
    end

    function automatic int pos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_move(input int c, input logic [1:0] nab, input bit zrise);
        int d;
        d = (pos(nab) - pos(ab_m[c]) + 4) % 4;
        case (d)
            1: begin cnt_m[c] = cnt_m[c] + 16'd1; dir_m[c] = 1'b1; end
            3: begin cnt_m[c] = cnt_m[c] - 16'd1; dir_m[c] = 1'b0; end
            2: begin
                cnt_m[c]  = dir_m[c] ? cnt_m[c] + 16'd2 : cnt_m[c] - 16'd2;
                skip_m[c] = 1'b1;
            end
            default: ;
        endcase
`ifdef QUAD_INDEX_CLEAR_EN
        if (zrise) cnt_m[c] = '0;
`endif
        ab_m[c] = nab;
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            cnt_m[i] = '0; dir_m[i] = 0; skip_m[i] = 0; ab_m[i] = 2'b00;
        end
    endtask

    task automatic move(input int c, input logic [1:0] nab, input bit zr);
        @(negedge clk);
        a[c] = nab[1];
        b[c] = nab[0];
        if (zr) z[c] = 1'b1;
        model_move(c, nab, zr);
        repeat (GAP) @(negedge clk);
    endtask

    task automatic start_read(input int ch);
        exp_t e;
        int   n;
        @(negedge clk);
        e.ch   = ch;
        e.cyc  = cyc;
        e.cnt  = (ch < CH) ? cnt_m[ch] : 16'h0;
        e.skip = (ch < CH) ? skip_m[ch] : 1'b0;
        expq.push_back(e);
        if (ch < CH) skip_m[ch] = 1'b0;
        rd_ch  = TW'(ch);
        rd_req = 1'b1;
        n = 0;
        while (!rd_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rd_ack) begin
            total++;
            bad++;
            $display("FAIL ack_timeout ch%0d: got no ack expected ack within 20 cycles", ch);
            if (expq.size() > 0) void'(expq.pop_back());
        end
    endtask

    task automatic do_read(input int ch);
        int n;
        start_read(ch);
        @(negedge clk);
        rd_req = 1'b0;
        n = 0;
        while (rd_ack && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("ack_release", 32'(rd_ack), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] nab;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset rd_ack", 32'(rd_ack), 32'd0);
        chk("reset rd_cnt", 32'(rd_cnt), 32'd0);
        chk("reset rd_skip", 32'(rd_skip), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // channel 1 full forward cycle
        move(1, 2'b01, 0); move(1, 2'b11, 0); move(1, 2'b10, 0); move(1, 2'b00, 0);
        do_read(1);

        // channel 0 backward through zero, then forward
        move(0, 2'b10, 0);
        do_read(0);
        move(0, 2'b00, 0); move(0, 2'b01, 0); move(0, 2'b11, 0);
        do_read(0);

        // channel 2 skipped step and sticky flag clear
        move(2, 2'b01, 0);
        move(2, 2'b10, 0);
        do_read(2);
        do_read(2);

        // channel 3 index pulse coincident with a step
        move(3, 2'b01, 0); move(3, 2'b11, 0); move(3, 2'b10, 0);
        move(3, 2'b00, 0); move(3, 2'b01, 0);
        move(3, 2'b11, 1);
        do_read(3);
        @(negedge clk);
        z = '0;
        repeat (GAP) @(negedge clk);

        // channel 0 wrap: down to FFFE, up to FFFF, then +2 skip to 0001
        move(0, 2'b01, 0); move(0, 2'b00, 0); move(0, 2'b10, 0); move(0, 2'b11, 0);
        move(0, 2'b10, 0);
        do_read(0);
        move(0, 2'b01, 0);
        do_read(0);

        do_read(7);

        for (int it = 0; it < 60; it++) begin
            @(negedge clk);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(1, 0) == 1) begin
                    nab  = 2'($urandom_range(3, 0));
                    a[c] = nab[1];
                    b[c] = nab[0];
                    model_move(c, nab, 0);
                end
            end
            repeat (GAP) @(negedge clk);
            if ($urandom_range(2, 0) == 0) do_read(int'($urandom_range(2**TW - 1, 0)));
        end
        for (int c = 0; c < CH; c++) do_read(c);

        // async reset while acknowledging
        start_read(1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("ack_async_reset", 32'(rd_ack), 32'd0);
        rd_req = 1'b0;
        a = '0; b = '0; z = '0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < CH; c++) do_read(c);
        do_read(7);

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
